// File: rtl/prover_interpolate_poly.sv
// Sumcheck round interpolator: turns f(0), f(1), f(-1) [, f(2)]
// into coefficients c0..c3 using shared modular add/halve/multiply units.

`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 16'd65521
`endif
`ifndef F_Q_P1_MI
`define F_Q_P1_MI 16'd65507
`endif
`ifndef F_INV3
`define F_INV3 16'd43681
`endif

// Modular adder, operands captured on en, result two cycles later.
module field_adder #(
    parameter int unsigned  W = `F_NBITS,
    parameter logic [W-1:0] Q = `F_Q
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         rdy
);
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         busy;

    // Operands may be non-canonical (negation input), so reduce up to 2q.
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {Q, 1'b0})
            s = s - {Q, 1'b0};
        else if (s >= {1'b0, Q})
            s = s - {1'b0, Q};
        return s[W-1:0];
    endfunction

    // Capture on en, compute on the following cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            a_q  <= '0;
            b_q  <= '0;
            res  <= '0;
            busy <= 1'b0;
        end else if (en) begin
            a_q  <= a;
            b_q  <= b;
            busy <= 1'b1;
        end else if (busy) begin
            res  <= mod_add(a_q, b_q);
            busy <= 1'b0;
        end
    end

    assign rdy = ~busy;
endmodule

// Modular halving: x/2 = x>>1 for even x, (x+q)>>1 for odd x.
module field_halve #(
    parameter int unsigned  W = `F_NBITS,
    parameter logic [W-1:0] Q = `F_Q
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         en,
    input  logic [W-1:0] a,
    output logic [W-1:0] res,
    output logic         rdy
);
    logic [W-1:0] a_q;
    logic         busy;

    function automatic logic [W-1:0] mod_halve(input logic [W-1:0] x);
        logic [W:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, Q}) : {1'b0, x};
        return s[W:1];
    endfunction

    // Capture on en, compute on the following cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            a_q  <= '0;
            res  <= '0;
            busy <= 1'b0;
        end else if (en) begin
            a_q  <= a;
            busy <= 1'b1;
        end else if (busy) begin
            res  <= mod_halve(a_q);
            busy <= 1'b0;
        end
    end

    assign rdy = ~busy;
endmodule

// Modular multiplier.
module field_multiplier #(
    parameter int unsigned  W = `F_NBITS,
    parameter logic [W-1:0] Q = `F_Q
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         rdy
);
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         busy;

    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        p = p % {{W{1'b0}}, Q};
        return p[W-1:0];
    endfunction

    // Capture on en, compute on the following cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            a_q  <= '0;
            b_q  <= '0;
            res  <= '0;
            busy <= 1'b0;
        end else if (en) begin
            a_q  <= a;
            b_q  <= b;
            busy <= 1'b1;
        end else if (busy) begin
            res  <= mod_mul(a_q, b_q);
            busy <= 1'b0;
        end
    end

    assign rdy = ~busy;
endmodule

module prover_interpolate_poly #(
    parameter int unsigned          MAX_DEGREE = 3,
    parameter logic [`F_NBITS-1:0] INV3       = `F_INV3
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    en,
    input  logic                    deg3_in,
    input  logic [4*`F_NBITS-1:0]   y_in,
    output logic [4*`F_NBITS-1:0]   c_out,
    output logic                    deg3_out,
    output logic                    ready_pulse,
    output logic                    ready
);
    localparam int unsigned  W     = `F_NBITS;
    localparam logic [W-1:0] NEG_K = `F_Q_P1_MI;

    typedef enum logic [3:0] {
        S_IDLE, S_Q0, S_Q1, S_Q2, S_Q3, S_Q4,
        S_C0, S_C1, S_C2, S_C3, S_C4, S_C5, S_C6, S_C7, S_C8,
        S_DONE
    } state_t;

    state_t       state;
    state_t       nxt;
    logic         en_dly;
    logic         ready_dly;
    logic         start;
    logic         deg3_eff;
    logic         issued;
    logic         go;

    logic [W-1:0] y0_r;
    logic [W-1:0] y1_r;
    logic [W-1:0] ym1_r;
    logic [W-1:0] y2_r;
    logic         mode_r;
    logic [W-1:0] r_c1;
    logic [W-1:0] r_c2;
    logic [W-1:0] r_c3;
    logic [W-1:0] t_b;
    logic [W-1:0] t_c;

    logic         en_add0;
    logic         en_add1;
    logic         en_hlv;
    logic         en_mul;
    logic         use_add0;
    logic         use_add1;
    logic         use_hlv;
    logic         use_mul;

    logic [W-1:0] add0_a;
    logic [W-1:0] add0_b;
    logic [W-1:0] add1_a;
    logic [W-1:0] add1_b;
    logic [W-1:0] hlv_a;
    logic [W-1:0] mul_a;
    logic [W-1:0] add0_res;
    logic [W-1:0] add1_res;
    logic [W-1:0] hlv_res;
    logic [W-1:0] mul_res;
    logic         add0_rdy;
    logic         add1_rdy;
    logic         hlv_rdy;
    logic         mul_rdy;

    assign deg3_eff    = (MAX_DEGREE >= 3) ? deg3_in : 1'b0;
    assign start       = en & ~en_dly;
    assign ready       = (state == S_IDLE) & ~start;
    assign ready_pulse = ready & ~ready_dly;
    assign go          = issued & ~(en_add0 | en_add1 | en_hlv | en_mul)
                         & add0_rdy & add1_rdy & hlv_rdy & mul_rdy;

    field_adder #(.W(W)) u_add0 (
        .clk(clk), .rstb(rstb), .en(en_add0),
        .a(add0_a), .b(add0_b), .res(add0_res), .rdy(add0_rdy)
    );

    field_adder #(.W(W)) u_add1 (
        .clk(clk), .rstb(rstb), .en(en_add1),
        .a(add1_a), .b(add1_b), .res(add1_res), .rdy(add1_rdy)
    );

    field_halve #(.W(W)) u_hlv (
        .clk(clk), .rstb(rstb), .en(en_hlv),
        .a(hlv_a), .res(hlv_res), .rdy(hlv_rdy)
    );

    if (MAX_DEGREE >= 3) begin : g_mul
        field_multiplier #(.W(W)) u_mul (
            .clk(clk), .rstb(rstb), .en(en_mul),
            .a(mul_a), .b(INV3), .res(mul_res), .rdy(mul_rdy)
        );
    end else begin : g_nomul
        assign mul_res = '0;
        assign mul_rdy = 1'b1;
    end

    // Edge detectors for en and ready.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            en_dly    <= 1'b1;
            ready_dly <= 1'b1;
        end else begin
            en_dly    <= en;
            ready_dly <= ready;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    // Per-state unit selection, operand routing and next state.
    always_comb begin
        nxt      = state;
        use_add0 = 1'b0;
        use_add1 = 1'b0;
        use_hlv  = 1'b0;
        use_mul  = 1'b0;
        add0_a   = '0;
        add0_b   = '0;
        add1_a   = '0;
        add1_b   = '0;
        hlv_a    = '0;
        mul_a    = '0;
        unique case (state)
            S_IDLE: begin
                if (start)
                    nxt = deg3_eff ? S_C0 : S_Q0;
            end
            S_Q0: begin
                use_add0 = 1'b1; add0_a = y1_r;      add0_b = ym1_r;
                use_add1 = 1'b1; add1_a = ~y0_r;     add1_b = NEG_K;
                if (go) nxt = S_Q1;
            end
            S_Q1: begin
                use_hlv  = 1'b1; hlv_a  = add0_res;
                use_add0 = 1'b1; add0_a = add1_res;  add0_b = y1_r;
                if (go) nxt = S_Q2;
            end
            S_Q2: begin
                use_add1 = 1'b1; add1_a = hlv_res;   add1_b = add1_res;
                if (go) nxt = S_Q3;
            end
            S_Q3: begin
                use_add1 = 1'b1; add1_a = ~add1_res; add1_b = NEG_K;
                if (go) nxt = S_Q4;
            end
            S_Q4: begin
                use_add0 = 1'b1; add0_a = add0_res;  add0_b = add1_res;
                if (go) nxt = S_DONE;
            end
            S_C0: begin
                use_add0 = 1'b1; add0_a = y1_r;      add0_b = ym1_r;
                use_add1 = 1'b1; add1_a = ~ym1_r;    add1_b = NEG_K;
                if (go) nxt = S_C1;
            end
            S_C1: begin
                use_hlv  = 1'b1; hlv_a  = add0_res;
                use_add0 = 1'b1; add0_a = y1_r;      add0_b = add1_res;
                use_add1 = 1'b1; add1_a = y2_r;      add1_b = add1_res;
                if (go) nxt = S_C2;
            end
            S_C2: begin
                use_hlv  = 1'b1; hlv_a  = add0_res;
                use_mul  = 1'b1; mul_a  = add1_res;
                use_add0 = 1'b1; add0_a = ~y0_r;     add0_b = NEG_K;
                if (go) nxt = S_C3;
            end
            S_C3: begin
                use_add0 = 1'b1; add0_a = t_b;       add0_b = add0_res;
                use_add1 = 1'b1; add1_a = ~hlv_res;  add1_b = NEG_K;
                if (go) nxt = S_C4;
            end
            S_C4: begin
                use_add1 = 1'b1; add1_a = mul_res;   add1_b = add1_res;
                use_add0 = 1'b1; add0_a = ~add0_res; add0_b = NEG_K;
                if (go) nxt = S_C5;
            end
            S_C5: begin
                use_add1 = 1'b1; add1_a = add1_res;  add1_b = add0_res;
                if (go) nxt = S_C6;
            end
            S_C6: begin
                use_hlv  = 1'b1; hlv_a  = add1_res;
                if (go) nxt = S_C7;
            end
            S_C7: begin
                use_add1 = 1'b1; add1_a = ~hlv_res;  add1_b = NEG_K;
                if (go) nxt = S_C8;
            end
            S_C8: begin
                use_add0 = 1'b1; add0_a = t_c;       add0_b = add1_res;
                if (go) nxt = S_DONE;
            end
            S_DONE: begin
                nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Fire each state's unit enables once as single-cycle pulses.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            issued  <= 1'b0;
            en_add0 <= 1'b0;
            en_add1 <= 1'b0;
            en_hlv  <= 1'b0;
            en_mul  <= 1'b0;
        end else if (state == S_IDLE || state == S_DONE) begin
            issued  <= 1'b0;
            en_add0 <= 1'b0;
            en_add1 <= 1'b0;
            en_hlv  <= 1'b0;
            en_mul  <= 1'b0;
        end else if (!issued) begin
            issued  <= 1'b1;
            en_add0 <= use_add0;
            en_add1 <= use_add1;
            en_hlv  <= use_hlv;
            en_mul  <= use_mul;
        end else begin
            en_add0 <= 1'b0;
            en_add1 <= 1'b0;
            en_hlv  <= 1'b0;
            en_mul  <= 1'b0;
            if (go)
                issued <= 1'b0;
        end
    end

    // Input capture at start and saving of values needed after reuse.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            y0_r   <= '0;
            y1_r   <= '0;
            ym1_r  <= '0;
            y2_r   <= '0;
            mode_r <= 1'b0;
            r_c1   <= '0;
            r_c2   <= '0;
            r_c3   <= '0;
            t_b    <= '0;
            t_c    <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                y0_r   <= y_in[0*W +: W];
                y1_r   <= y_in[1*W +: W];
                ym1_r  <= y_in[2*W +: W];
                y2_r   <= y_in[3*W +: W];
                mode_r <= deg3_eff;
                r_c3   <= '0;
            end
        end else if (go) begin
            unique case (state)
                S_Q2:    r_c2 <= add1_res;
                S_Q4:    r_c1 <= add0_res;
                S_C1:    t_b  <= hlv_res;
                S_C2:    t_c  <= hlv_res;
                S_C3:    r_c2 <= add0_res;
                S_C6:    r_c3 <= hlv_res;
                S_C8:    r_c1 <= add0_res;
                default: ;
            endcase
        end
    end

    // Result registers change only in DONE, all together.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            c_out    <= '0;
            deg3_out <= 1'b0;
        end else if (state == S_DONE) begin
            c_out    <= {r_c3, r_c2, r_c1, y0_r};
            deg3_out <= mode_r;
        end
    end
endmodule

// File: tb/tb_prover_interpolate_poly.sv
// Directed bench for prover_interpolate_poly, cubic and quadratic-only builds.
// Expected coefficients are worked out by hand for q = 65521.

module tb_prover_interpolate_poly;
    localparam int W = 16;
    localparam logic [W-1:0] Q = 16'd65521;

    logic           clk;
    logic           rstb;
    logic           en;
    logic           deg3_in;
    logic [4*W-1:0] y_in;
    logic [4*W-1:0] c_out;
    logic           deg3_out;
    logic           ready_pulse;
    logic           ready;
    logic [4*W-1:0] c2_out;
    logic           deg3_2_out;
    logic           ready2_pulse;
    logic           ready2;

    int checks = 0;
    int errors = 0;

    prover_interpolate_poly #(.MAX_DEGREE(3)) dut (
        .clk(clk), .rstb(rstb), .en(en), .deg3_in(deg3_in), .y_in(y_in),
        .c_out(c_out), .deg3_out(deg3_out),
        .ready_pulse(ready_pulse), .ready(ready)
    );

    prover_interpolate_poly #(.MAX_DEGREE(2)) dut2 (
        .clk(clk), .rstb(rstb), .en(en), .deg3_in(deg3_in), .y_in(y_in),
        .c_out(c2_out), .deg3_out(deg3_2_out),
        .ready_pulse(ready2_pulse), .ready(ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic [4*W-1:0] obs,
                         input logic [W-1:0] e0, input logic [W-1:0] e1,
                         input logic [W-1:0] e2, input logic [W-1:0] e3);
        chk({tag, "_c0"}, 64'(obs[0*W +: W]), 64'(e0));
        chk({tag, "_c1"}, 64'(obs[1*W +: W]), 64'(e1));
        chk({tag, "_c2"}, 64'(obs[2*W +: W]), 64'(e2));
        chk({tag, "_c3"}, 64'(obs[3*W +: W]), 64'(e3));
    endtask

    task automatic run_job(input string tag, input logic d3,
                           input logic [W-1:0] v0, input logic [W-1:0] v1,
                           input logic [W-1:0] v2, input logic [W-1:0] v3,
                           input bit disturb);
        logic [4*W-1:0] prev;
        bit seen;
        bit stable;
        @(negedge clk);
        y_in    = {v3, v2, v1, v0};
        deg3_in = d3;
        en      = 1'b1;
        prev    = c_out;
        seen    = 1'b0;
        stable  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (ready_pulse) begin
                seen = 1'b1;
            end else begin
                if (c_out !== prev) stable = 1'b0;
                if (disturb && i < 12) begin
                    y_in    = {16'($urandom), 16'($urandom),
                               16'($urandom), 16'($urandom)};
                    deg3_in = i[0];
                    en      = (i % 3 == 1);
                end else begin
                    en = 1'b0;
                end
                @(negedge clk);
            end
        end
        en = 1'b0;
        chk({tag, "_done"}, 64'(seen), 64'd1);
        chk({tag, "_stable"}, 64'(stable), 64'd1);
        chk({tag, "_ready"}, 64'(ready), 64'd1);
    endtask

    task automatic quiet(input string tag, input int n);
        int extra;
        logic [4*W-1:0] held;
        bit stable;
        extra  = 0;
        held   = c_out;
        stable = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ready_pulse) extra++;
            if (c_out !== held) stable = 1'b0;
        end
        chk({tag, "_no_extra_pulse"}, 64'(extra), 64'd0);
        chk({tag, "_held"}, 64'(stable), 64'd1);
    endtask

    initial begin
        bit idle_ok;
        rstb    = 1'b0;
        en      = 1'b0;
        deg3_in = 1'b0;
        y_in    = '0;
        #23;
        chk("rst_c_out", 64'(c_out), 64'd0);
        chk("rst_deg3", 64'(deg3_out), 64'd0);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_pulse", 64'(ready_pulse), 64'd0);
        @(negedge clk);
        rstb = 1'b1;
        quiet("post_rst", 3);

        run_job("quad", 1'b0, 16'd1, 16'd6, 16'd2, 16'd17, 1'b0);
        chk_c("quad", c_out, 16'd1, 16'd2, 16'd3, 16'd0);
        chk("quad_deg3", 64'(deg3_out), 64'd0);
        chk_c("quad_m2", c2_out, 16'd1, 16'd2, 16'd3, 16'd0);
        quiet("quad", 5);

        run_job("cub", 1'b1, 16'd1, 16'd10, Q - 16'd2, 16'd49, 1'b0);
        chk_c("cub", c_out, 16'd1, 16'd2, 16'd3, 16'd4);
        chk("cub_deg3", 64'(deg3_out), 64'd1);
        chk_c("cub_m2", c2_out, 16'd1, 16'd6, 16'd3, 16'd0);
        chk("cub_m2_deg3", 64'(deg3_2_out), 64'd0);
        quiet("cub", 5);

        run_job("negx", 1'b0, 16'd0, Q - 16'd1, 16'd1, 16'd0, 1'b0);
        chk_c("negx", c_out, 16'd0, Q - 16'd1, 16'd0, 16'd0);
        chk("negx_deg3", 64'(deg3_out), 64'd0);

        run_job("negx3", 1'b1, 16'd0, Q - 16'd1, 16'd1, Q - 16'd8, 1'b0);
        chk_c("negx3", c_out, 16'd0, 16'd0, 16'd0, Q - 16'd1);
        chk("negx3_deg3", 64'(deg3_out), 64'd1);

        run_job("busy", 1'b1, 16'd1, 16'd10, Q - 16'd2, 16'd49, 1'b1);
        chk_c("busy", c_out, 16'd1, 16'd2, 16'd3, 16'd4);
        chk("busy_deg3", 64'(deg3_out), 64'd1);
        quiet("busy", 60);

        @(negedge clk);
        y_in    = {16'd49, Q - 16'd2, 16'd10, 16'd1};
        deg3_in = 1'b1;
        en      = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy", 64'(ready), 64'd0);
        en = 1'b1;
        @(negedge clk);
        rstb = 1'b0;
        #1;
        chk("mid_rst_c_out", 64'(c_out), 64'd0);
        chk("mid_rst_ready", 64'(ready), 64'd1);
        chk("mid_rst_deg3", 64'(deg3_out), 64'd0);
        @(negedge clk);
        rstb = 1'b1;
        idle_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!ready || ready_pulse) idle_ok = 1'b0;
        end
        chk("en_high_no_start", 64'(idle_ok), 64'd1);
        chk("en_high_c_out", 64'(c_out), 64'd0);
        en = 1'b0;

        run_job("m2", 1'b1, 16'd1, 16'd6, 16'd2, 16'd17, 1'b0);
        chk_c("m2_cubic_build", c_out, 16'd1, 16'd2, 16'd3, 16'd0);
        chk("m2_cubic_deg3", 64'(deg3_out), 64'd1);
        chk_c("m2_quad_build", c2_out, 16'd1, 16'd2, 16'd3, 16'd0);
        chk("m2_quad_deg3", 64'(deg3_2_out), 64'd0);
        chk("m2_quad_ready", 64'(ready2), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
